// File: rtl/mp_nu_pkg.sv
// Shared types and helpers for the multi-precision neural MAC unit.
package mp_nu_pkg;

    typedef enum logic [1:0] {
        MODE_8B  = 2'd0,
        MODE_4B  = 2'd1,
        MODE_2B  = 2'd2,
        MODE_ILL = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_REQ   = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned MAX_K  = 16;
    localparam int unsigned PROD_W = 18;
    localparam int unsigned SUM_W  = 22;
    localparam int unsigned BIAS_W = 8;

    // Clamp a signed value to the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

endpackage

// File: rtl/mp_neural_unit_lane.sv
// One output channel: precision decode, registered products, registered
// adder tree and saturating accumulator with sticky clamp flag.
module mp_lane_mac
    import mp_nu_pkg::*;
#(
    parameter int unsigned ACC_W = 32
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  mode_t             mode,
    input  logic              load,
    input  logic [ACC_W-1:0]  load_val,
    input  logic              beat,
    input  logic [WORD_W-1:0] weights,
    input  logic [WORD_W-1:0] act,
    output logic [ACC_W-1:0]  acc,
    output logic              sat,
    output logic              busy_c
);

    logic signed [PROD_W-1:0] prod_c [MAX_K];
    logic signed [PROD_W-1:0] prod_q [MAX_K];
    logic signed [SUM_W-1:0]  sum_c;
    logic signed [SUM_W-1:0]  sum_q;
    logic                     v1;
    logic                     v2;
    logic signed [63:0]       acc_ext;
    logic signed [63:0]       acc_clamp;

    // Signed weight x unsigned activation; illegal mode decodes as 8-bit.
    always_comb begin
        for (int k = 0; k < MAX_K; k++) prod_c[k] = '0;
        case (mode)
            MODE_4B: for (int k = 0; k < 8; k++)
                prod_c[k] = PROD_W'($signed(weights[k*4 +: 4])) *
                            PROD_W'($signed({1'b0, act[k*4 +: 4]}));
            MODE_2B: for (int k = 0; k < 16; k++)
                prod_c[k] = PROD_W'($signed(weights[k*2 +: 2])) *
                            PROD_W'($signed({1'b0, act[k*2 +: 2]}));
            default: for (int k = 0; k < 4; k++)
                prod_c[k] = PROD_W'($signed(weights[k*8 +: 8])) *
                            PROD_W'($signed({1'b0, act[k*8 +: 8]}));
        endcase
    end

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < MAX_K; k++) sum_c = sum_c + SUM_W'(prod_q[k]);
    end

    assign acc_ext   = 64'($signed(acc)) + 64'(sum_q);
    assign acc_clamp = sat_signed(acc_ext, ACC_W);
    assign busy_c    = v1 | v2;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < MAX_K; k++) prod_q[k] <= '0;
            sum_q <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            acc   <= '0;
            sat   <= 1'b0;
        end else if (load) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            acc <= load_val;
            sat <= 1'b0;
        end else begin
            v1 <= beat;
            v2 <= v1;
            if (beat) for (int k = 0; k < MAX_K; k++) prod_q[k] <= prod_c[k];
            if (v1) sum_q <= sum_c;
            if (v2) begin
                acc <= ACC_W'(acc_clamp);
                if (acc_clamp != acc_ext) sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mp_neural_unit.sv
// Multi-precision N-channel neural MAC: control FSM, bias load, per-channel
// requantiser and result handshake around N_CH lane accumulators.
module mp_neural_unit
    import mp_nu_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned MUL_W = 16,
    parameter int unsigned OUT_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    bias_in,
    input  logic [N_CH*BIAS_W-1:0]  bias_vals,
    input  logic [4:0]              bias_shift,
    input  logic [1:0]              mode,
    input  logic                    valid_in,
    output logic                    in_ready,
    input  logic [N_CH*WORD_W-1:0]  weights,
    input  logic [WORD_W-1:0]       input_val,
    input  logic                    get_res,
    input  logic [N_CH*MUL_W-1:0]   out_mul,
    input  logic [5:0]              out_shift,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [N_CH*OUT_W-1:0]   output_val,
    output logic [N_CH-1:0]         acc_sat,
    output logic                    mode_err
);

    localparam int unsigned PW = ACC_W + MUL_W;

    state_t            state;
    state_t            state_nxt_c;
    mode_t             mode_q;
    logic              load_c;
    logic              beat_c;
    logic [N_CH-1:0]   busy_v;
    logic              busy_c;
    logic [ACC_W-1:0]  acc   [N_CH];
    logic [OUT_W-1:0]  req_c [N_CH];

    assign load_c = bias_in && (state != ST_REQ);
    assign beat_c = valid_in && in_ready;
    assign busy_c = |busy_v;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [ACC_W-1:0]     bias_ext;
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] rnd;
        logic signed [PW-1:0] shifted;
        logic signed [63:0]   clamped;

        assign bias_ext = ACC_W'($signed(bias_vals[c*BIAS_W +: BIAS_W])) << bias_shift;

        mp_lane_mac #(.ACC_W(ACC_W)) u_lane (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .mode     (mode_q),
            .load     (load_c),
            .load_val (bias_ext),
            .beat     (beat_c),
            .weights  (weights[c*WORD_W +: WORD_W]),
            .act      (input_val),
            .acc      (acc[c]),
            .sat      (acc_sat[c]),
            .busy_c   (busy_v[c])
        );

        // Round-half-up arithmetic shift, then clamp to the output width.
        assign prod    = PW'($signed(acc[c])) * PW'($signed(out_mul[c*MUL_W +: MUL_W]));
        assign rnd     = (out_shift != 6'd0) ? (PW'(1) << (out_shift - 6'd1)) : '0;
        assign shifted = (prod + rnd) >>> out_shift;
        assign clamped = sat_signed(64'(shifted), OUT_W);
        assign req_c[c] = OUT_W'(clamped);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= ST_IDLE;
        else         state <= state_nxt_c;
    end

    // Bias load takes priority over everything except the single REQ cycle.
    always_comb begin
        state_nxt_c = state;
        if (load_c) begin
            state_nxt_c = ST_ACC;
        end else begin
            case (state)
                ST_IDLE:  if (get_res)   state_nxt_c = ST_REQ;
                ST_ACC:   if (get_res)   state_nxt_c = ST_DRAIN;
                ST_DRAIN: if (!busy_c)   state_nxt_c = ST_REQ;
                ST_REQ:                  state_nxt_c = ST_HOLD;
                ST_HOLD:  if (res_ready) state_nxt_c = ST_IDLE;
                default:                 state_nxt_c = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
        in_ready  = (state == ST_ACC) && !get_res;
        res_valid = (state == ST_HOLD);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mode_q     <= MODE_8B;
            mode_err   <= 1'b0;
            output_val <= '0;
        end else begin
            if (load_c) begin
                mode_q   <= mode_t'(mode);
                mode_err <= (mode == 2'd3);
            end
            if (state == ST_REQ)
                for (int c = 0; c < N_CH; c++) output_val[c*OUT_W +: OUT_W] <= req_c[c];
        end
    end

endmodule
